// File: rtl/heat_stencil_engine.sv
// heat_stencil_engine
//
// Compute core of the 2^GRID_LOG2 x 2^GRID_LOG2 heat-diffusion solver.
// Each sweep visits every cell in raster order, reads the neighbourhood from
// the source bank (disp_bank) and writes the updated temperature into the
// other bank:
//     T' = T + floor(alpha * (N + S + E + W - 4T) / 256), clamped to 0..255
// Edge cells either take boundary_temp (Dirichlet) or keep their value
// (Neumann / insulated). After the final cell the banks swap roles, so
// disp_bank always names the newest complete grid.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   run             1 = sweep, 0 = pause at the next cell boundary
//   alpha           diffusion coefficient, units of 1/256
//   boundary_temp   Dirichlet edge temperature
//   boundary_type   00 Dirichlet, 01 Neumann, 10/11 treated as Dirichlet
//   mem_addr        RAM address {bank, y, x}
//   mem_rd_en       read strobe; mem_rdata valid the following cycle
//   mem_rdata       RAM read data
//   mem_wr_en       write strobe
//   mem_wdata       RAM write data
//   disp_bank       bank holding the latest complete grid
//   busy            high while a cell is being processed
//   sweep_done      one-cycle pulse after each completed sweep
//   sweep_count     number of completed sweeps (wraps)

module heat_stencil_engine #(
    parameter int GRID_LOG2 = 5,
    parameter int AW        = 2*GRID_LOG2+1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic [7:0]    alpha,
    input  logic [7:0]    boundary_temp,
    input  logic [1:0]    boundary_type,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd_en,
    input  logic [7:0]    mem_rdata,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wdata,
    output logic          disp_bank,
    output logic          busy,
    output logic          sweep_done,
    output logic [15:0]   sweep_count
);

    localparam int G = GRID_LOG2;
    localparam logic [G-1:0] XMAX = '1;
    localparam logic [G-1:0] ONE  = G'(1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD_C = 3'd1;
    localparam logic [2:0] S_RD_N = 3'd2;
    localparam logic [2:0] S_RD_S = 3'd3;
    localparam logic [2:0] S_RD_W = 3'd4;
    localparam logic [2:0] S_RD_E = 3'd5;
    localparam logic [2:0] S_CALC = 3'd6;
    localparam logic [2:0] S_WR   = 3'd7;

    logic [2:0]   state_q, state_d;
    logic [G-1:0] x_q, x_d;
    logic [G-1:0] y_q, y_d;
    logic         disp_q, disp_d;
    logic [15:0]  cnt_q, cnt_d;
    logic         done_q, done_d;

    // Shadow copies of the configuration, held for a whole sweep
    logic [7:0]   alpha_q, alpha_d;
    logic [7:0]   btemp_q, btemp_d;
    logic         neu_q, neu_d;

    // Captured neighbourhood and registered result
    logic [7:0]   c_q, c_d;
    logic [7:0]   n_q, n_d;
    logic [7:0]   s_q, s_d;
    logic [7:0]   w_q, w_d;
    logic [7:0]   res_q, res_d;

    logic         live_neu;
    logic         cur_edge;
    logic         last_cell;

    // Datapath
    logic [9:0]          nb_sum;
    logic [9:0]          c_x4;
    logic signed [10:0]  lap;
    logic signed [18:0]  prod;
    logic signed [10:0]  delta;
    logic signed [11:0]  sum_new;
    logic [7:0]          res_calc;

    // Dirichlet edges skip straight to the write; everything else starts
    // with the centre read.
    function automatic logic [2:0] first_state(input logic [G-1:0] fx,
                                               input logic [G-1:0] fy,
                                               input logic         neu);
        logic edge_cell;
        edge_cell = (fx == '0) || (fx == XMAX) || (fy == '0) || (fy == XMAX);
        return (edge_cell && !neu) ? S_WR : S_RD_C;
    endfunction

    assign live_neu  = (boundary_type == 2'b01);
    assign cur_edge  = (x_q == '0) || (x_q == XMAX) || (y_q == '0) || (y_q == XMAX);
    assign last_cell = (x_q == XMAX) && (y_q == XMAX);

    // The east neighbour is consumed straight off mem_rdata in CALC.
    always_comb begin
        nb_sum  = {2'b00, n_q} + {2'b00, s_q} + {2'b00, w_q} + {2'b00, mem_rdata};
        c_x4    = {c_q, 2'b00};
        lap     = $signed({1'b0, nb_sum}) - $signed({1'b0, c_x4});
        prod    = 19'($signed({1'b0, alpha_q})) * 19'(lap);
        delta   = 11'(prod >>> 8);
        sum_new = $signed({4'b0000, c_q}) + $signed({delta[10], delta});
        if (sum_new[11]) begin
            res_calc = 8'd0;
        end else if (sum_new[10:8] != 3'b000) begin
            res_calc = 8'd255;
        end else begin
            res_calc = sum_new[7:0];
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        disp_d  = disp_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        alpha_d = alpha_q;
        btemp_d = btemp_q;
        neu_d   = neu_q;
        c_d     = c_q;
        n_d     = n_q;
        s_d     = s_q;
        w_d     = w_q;
        res_d   = res_q;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    // Resuming at (0,0) means a fresh sweep: latch new config
                    if ((x_q == '0) && (y_q == '0)) begin
                        alpha_d = alpha;
                        btemp_d = boundary_temp;
                        neu_d   = live_neu;
                        state_d = first_state(x_q, y_q, live_neu);
                    end else begin
                        state_d = first_state(x_q, y_q, neu_q);
                    end
                end
            end
            S_RD_C: begin
                // Only Neumann edges reach RD_C as edges; they copy C in WR
                state_d = cur_edge ? S_WR : S_RD_N;
            end
            S_RD_N: begin
                c_d     = mem_rdata;
                state_d = S_RD_S;
            end
            S_RD_S: begin
                n_d     = mem_rdata;
                state_d = S_RD_W;
            end
            S_RD_W: begin
                s_d     = mem_rdata;
                state_d = S_RD_E;
            end
            S_RD_E: begin
                w_d     = mem_rdata;
                state_d = S_CALC;
            end
            S_CALC: begin
                res_d   = res_calc;
                state_d = S_WR;
            end
            S_WR: begin
                x_d = x_q + ONE;
                if (x_q == XMAX) begin
                    y_d = y_q + ONE;
                end
                if (last_cell) begin
                    disp_d = ~disp_q;
                    cnt_d  = cnt_q + 16'd1;
                    done_d = 1'b1;
                end
                if (!run) begin
                    state_d = S_IDLE;
                end else if (last_cell) begin
                    alpha_d = alpha;
                    btemp_d = boundary_temp;
                    neu_d   = live_neu;
                    state_d = first_state(x_d, y_d, live_neu);
                end else begin
                    state_d = first_state(x_d, y_d, neu_q);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            disp_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            alpha_q <= '0;
            btemp_q <= '0;
            neu_q   <= 1'b0;
            c_q     <= '0;
            n_q     <= '0;
            s_q     <= '0;
            w_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            disp_q  <= disp_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            alpha_q <= alpha_d;
            btemp_q <= btemp_d;
            neu_q   <= neu_d;
            c_q     <= c_d;
            n_q     <= n_d;
            s_q     <= s_d;
            w_q     <= w_d;
            res_q   <= res_d;
        end
    end

    // Memory interface decoded from the state; reads and writes are in
    // disjoint states so the strobes can never overlap.
    always_comb begin
        mem_addr  = '0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_wdata = '0;
        case (state_q)
            S_RD_C: begin
                mem_rd_en = 1'b1;
                mem_addr  = {disp_q, y_q, x_q};
            end
            S_RD_N: begin
                mem_rd_en = 1'b1;
                mem_addr  = {disp_q, y_q - ONE, x_q};
            end
            S_RD_S: begin
                mem_rd_en = 1'b1;
                mem_addr  = {disp_q, y_q + ONE, x_q};
            end
            S_RD_W: begin
                mem_rd_en = 1'b1;
                mem_addr  = {disp_q, y_q, x_q - ONE};
            end
            S_RD_E: begin
                mem_rd_en = 1'b1;
                mem_addr  = {disp_q, y_q, x_q + ONE};
            end
            S_WR: begin
                mem_wr_en = 1'b1;
                mem_addr  = {~disp_q, y_q, x_q};
                if (!cur_edge) begin
                    mem_wdata = res_q;
                end else if (neu_q) begin
                    mem_wdata = mem_rdata;
                end else begin
                    mem_wdata = btemp_q;
                end
            end
            default: begin
                mem_addr = '0;
            end
        endcase
    end

    assign disp_bank   = disp_q;
    assign busy        = (state_q != S_IDLE);
    assign sweep_done  = done_q;
    assign sweep_count = cnt_q;

endmodule

// File: tb/tb_heat_stencil_engine.sv
// tb_heat_stencil_engine
//
// Drives heat_stencil_engine against a behavioural two-bank RAM. Each sweep
// has its full expected write stream (address + data, raster order) queued
// up front from hand-derived grids; an independent monitor pops one entry
// per observed write.

module tb_heat_stencil_engine;

    localparam int GL = 5;
    localparam int AW = 2*GL+1;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic [7:0]    alpha;
    logic [7:0]    boundary_temp;
    logic [1:0]    boundary_type;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [7:0]    mem_rdata;
    logic          mem_wr_en;
    logic [7:0]    mem_wdata;
    logic          disp_bank;
    logic          busy;
    logic          sweep_done;
    logic [15:0]   sweep_count;

    heat_stencil_engine #(.GRID_LOG2(GL), .AW(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .alpha         (alpha),
        .boundary_temp (boundary_temp),
        .boundary_type (boundary_type),
        .mem_addr      (mem_addr),
        .mem_rd_en     (mem_rd_en),
        .mem_rdata     (mem_rdata),
        .mem_wr_en     (mem_wr_en),
        .mem_wdata     (mem_wdata),
        .disp_bank     (disp_bank),
        .busy          (busy),
        .sweep_done    (sweep_done),
        .sweep_count   (sweep_count)
    );

    always #5 clk = ~clk;

    // RAM model: one-cycle read latency, image load on request
    logic [7:0] mem [0:2047];
    logic [7:0] img [0:2047];
    logic       load_req;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 2048; i++) mem[i] <= img[i];
        end else if (mem_wr_en) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    int          errors;
    int          checks;
    logic [18:0] sb_q [$];
    bit          sb_strict;
    logic [18:0] mon_exp;
    logic [7:0]  eg [0:1023];

    // Monitor: strobe exclusivity and write-stream scoreboard
    always @(negedge clk) begin
        if (mem_rd_en || mem_wr_en) begin
            checks++;
            if (mem_rd_en && mem_wr_en) begin
                errors++;
                $display("FAIL strobe_excl: rd_en=%0b wr_en=%0b, required not both", mem_rd_en, mem_wr_en);
            end
        end
        if (mem_wr_en) begin
            if (sb_q.size() > 0) begin
                mon_exp = sb_q.pop_front();
                checks++;
                if ({mem_addr, mem_wdata} !== mon_exp) begin
                    errors++;
                    $display("FAIL wr_cell: got addr=%h data=%0d, required addr=%h data=%0d",
                             mem_addr, mem_wdata, mon_exp[18:8], mon_exp[7:0]);
                end
            end else if (sb_strict) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wr: got addr=%h data=%0d, required no write", mem_addr, mem_wdata);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic img_clear();
        for (int i = 0; i < 2048; i++) img[i] = 8'd0;
    endtask

    task automatic eg_clear();
        for (int i = 0; i < 1024; i++) eg[i] = 8'd0;
    endtask

    task automatic set_img(input int b, input int x, input int y, input logic [7:0] v);
        img[b*1024 + y*32 + x] = v;
    endtask

    task automatic set_eg(input int x, input int y, input logic [7:0] v);
        eg[y*32 + x] = v;
    endtask

    task automatic load_img();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic push_expected(input logic dst);
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++)
                sb_q.push_back({dst, 5'(y), 5'(x), eg[y*32 + x]});
    endtask

    task automatic hot_expected();
        eg_clear();
        set_eg(15, 16, 8'd63);
        set_eg(17, 16, 8'd63);
        set_eg(16, 15, 8'd63);
        set_eg(16, 17, 8'd63);
    endtask

    // Runs one sweep from IDLE; len counts busy cycles. Optional pause and
    // mid-sweep configuration change at given busy-cycle indices.
    task automatic sweep(input int len, input int pause_at, input int shadow_at,
                         input bit neu, input logic dst);
        int          c;
        int          guard;
        int          g2;
        int          bad;
        logic [12:0] want_first;
        c     = 0;
        guard = 0;
        run   = 1'b1;
        want_first = neu ? {2'b10, ~dst, 10'd0} : {2'b01, dst, 10'd0};
        while (c < len && guard < 12000) begin
            @(negedge clk);
            guard++;
            if (busy) c++;
            if (guard == 1)
                check("first_strobe", {mem_rd_en, mem_wr_en, mem_addr}, want_first);
            if (shadow_at != 0 && c == shadow_at) begin
                alpha         = 8'd0;
                boundary_temp = 8'd99;
                boundary_type = 2'b01;
            end
            if (pause_at != 0 && c == pause_at) begin
                run = 1'b0;
                g2  = 0;
                while (busy && g2 < 10) begin
                    @(negedge clk);
                    guard++;
                    g2++;
                    if (busy) c++;
                end
                check("pause_busy_low", busy, 0);
                bad = 0;
                repeat (500) begin
                    @(negedge clk);
                    guard++;
                    if (busy || mem_rd_en || mem_wr_en) bad++;
                end
                check("pause_quiet", bad, 0);
                run = 1'b1;
            end
        end
        if (c < len) begin
            check("sweep_timeout", c, len);
            run = 1'b0;
            return;
        end
        check("last_write", {mem_wr_en, mem_addr}, {1'b1, dst, 10'h3FF});
        check("done_early", sweep_done, 0);
        run = 1'b0;
        @(negedge clk);
        check("sweep_done_pulse", sweep_done, 1);
        check("busy_after", busy, 0);
        check("disp_bank_after", disp_bank, dst);
        @(negedge clk);
        check("sweep_done_once", sweep_done, 0);
        check("sb_drained", sb_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; run = 1'b0; alpha = 8'd0; boundary_temp = 8'd0; boundary_type = 2'b00;
        load_req = 1'b0; sb_strict = 1'b1; errors = 0; checks = 0;

        // Reset held with run=1, then hot-spot sweep
        img_clear();
        set_img(0, 16, 16, 8'd255);
        load_img();
        alpha = 8'd64;
        run   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_strobes", {mem_rd_en, mem_wr_en}, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_disp_bank", disp_bank, 0);
        check("rst_sweep_count", sweep_count, 0);
        check("rst_sweep_done", sweep_done, 0);
        hot_expected();
        push_expected(1'b1);
        rst = 1'b0;
        sweep(6424, 0, 0, 1'b0, 1'b1);
        check("hot_sweep_count", sweep_count, 1);

        // Saturation in both directions, alpha=255
        rst = 1'b1;
        run = 1'b0;
        img_clear();
        set_img(0, 8, 7, 8'd255);
        set_img(0, 8, 9, 8'd255);
        set_img(0, 7, 8, 8'd255);
        set_img(0, 9, 8, 8'd255);
        set_img(0, 20, 20, 8'd255);
        load_img();
        alpha = 8'd255;
        repeat (2) @(negedge clk);
        eg_clear();
        set_eg(8, 8, 8'd255);
        set_eg(6, 8, 8'd254);  set_eg(10, 8, 8'd254);
        set_eg(8, 6, 8'd254);  set_eg(8, 10, 8'd254);
        set_eg(7, 7, 8'd255);  set_eg(9, 7, 8'd255);
        set_eg(7, 9, 8'd255);  set_eg(9, 9, 8'd255);
        set_eg(19, 20, 8'd254); set_eg(21, 20, 8'd254);
        set_eg(20, 19, 8'd254); set_eg(20, 21, 8'd254);
        push_expected(1'b1);
        rst = 1'b0;
        sweep(6424, 0, 0, 1'b0, 1'b1);

        // Neumann: edges copied, boundary_temp ignored
        rst = 1'b1;
        img_clear();
        set_img(0, 0, 5, 8'd200);
        load_img();
        alpha         = 8'd64;
        boundary_temp = 8'd77;
        boundary_type = 2'b01;
        repeat (2) @(negedge clk);
        eg_clear();
        set_eg(0, 5, 8'd200);
        set_eg(1, 5, 8'd50);
        push_expected(1'b1);
        rst = 1'b0;
        sweep(6548, 0, 0, 1'b1, 1'b1);

        // Pause/resume with config changed mid-sweep
        rst = 1'b1;
        img_clear();
        set_img(0, 16, 16, 8'd255);
        load_img();
        alpha         = 8'd64;
        boundary_temp = 8'd0;
        boundary_type = 2'b00;
        repeat (2) @(negedge clk);
        hot_expected();
        push_expected(1'b1);
        rst = 1'b0;
        sweep(6424, 3000, 50, 1'b0, 1'b1);
        check("pause_sweep_count", sweep_count, 1);

        // Reset in the middle of the second sweep
        sb_strict = 1'b0;
        run = 1'b1;
        repeat (1000) @(negedge clk);
        check("sweep2_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_sweep_count", sweep_count, 0);
        check("midrst_disp_bank", disp_bank, 0);
        check("midrst_busy", busy, 0);
        check("midrst_strobes", {mem_rd_en, mem_wr_en}, 0);
        rst = 1'b0;
        run = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
